// File: rtl/memexp_arbiter.sv
// memexp_arbiter: shares one 16K x 16 expansion RAM between the TMS9900 CPU bus
//   and an 8-bit wishbone debug/loader port. Each access is sequenced by a small
//   FSM; CPU cycles are stretched through cpu_ready, wishbone cycles end with a
//   one-clock wb_ack_o pulse.
// Latency (uncontended): writes complete 1 clk after request, reads
//   read_latency+1 clk after request. A CPU access waits at most one full
//   wishbone access.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   cpu_cs/we/dbin/a/d    - CPU request (cpu_a is the 15-bit word address)
//   cpu_q, cpu_ready      - registered CPU read data, bus-cycle ready
//   wb_*                  - 8-bit wishbone slave (byte address, one-byte lane)
//   mem_a/we/be/d, mem_q  - RAM port; mem_q valid read_latency clk after issue
// Bit order: all buses are declared [N:0], so TMS bit 0 (MSB) is index N.
//   mem_be[0] enables the even byte (d[15:8]), mem_be[1] the odd byte (d[7:0]).
// Option: define MEMEXP_WB_PRIORITY_EN to make wishbone win every simultaneous
//   request; otherwise simultaneous requests alternate between the two masters.
module memexp_arbiter #(
  parameter int read_latency = 1  // legal 1..3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic        cpu_dbin,
  input  logic [14:0] cpu_a,
  input  logic [15:0] cpu_d,
  output logic [15:0] cpu_q,
  output logic        cpu_ready,
  input  logic [14:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [13:0] mem_a,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_d,
  input  logic [15:0] mem_q
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_RD   = 3'd1,
    CPU_DONE = 3'd2,
    WB_RD    = 3'd3,
    WB_ACK   = 3'd4
  } state_t;

  // Last wait-cycle index of a read: data is captured on the edge that ends it.
  localparam logic [1:0] LAT_LAST = 2'(read_latency - 1);

  state_t      state_q, state_d;
  logic        last_wb_q, last_wb_d;   // 1: last grant went to wishbone
  logic [1:0]  cnt_q, cnt_d;
  logic [13:0] addr_q, addr_d;         // RAM word held during a read
  logic [14:0] cpu_a_q, cpu_a_d;       // CPU address of the granted access
  logic        wb_odd_q, wb_odd_d;     // wishbone byte lane of the granted access
  logic [15:0] cpu_q_q, cpu_q_d;
  logic [7:0]  wb_dat_q, wb_dat_d;

  logic        cpu_req, wb_req, grant_cpu, grant_wb;
  logic        cpu_mapped;
  logic [13:0] cpu_map;

  // Expansion windows. Word >1000..>1FFF minus >1000 keeps only the low 12 bits;
  // words >5000..>7FFF minus >4000 simply drop address bit 14.
  always_comb begin
    cpu_mapped = 1'b0;
    cpu_map    = 14'h0000;
    case (cpu_a[14:12])
      3'b001: begin
        cpu_mapped = 1'b1;
        cpu_map    = {2'b00, cpu_a[11:0]};
      end
      3'b101, 3'b110, 3'b111: begin
        cpu_mapped = 1'b1;
        cpu_map    = cpu_a[13:0];
      end
      default: ;
    endcase
  end

  assign cpu_req = cpu_cs && (cpu_we || cpu_dbin);
  assign wb_req  = wb_cyc_i && wb_stb_i;

`ifdef MEMEXP_WB_PRIORITY_EN
  assign grant_cpu = cpu_req && !wb_req;
`else
  // On a tie the master that did not get the previous grant goes first.
  assign grant_cpu = cpu_req && (!wb_req || last_wb_q);
`endif
  assign grant_wb = wb_req && !grant_cpu;

  always_comb begin
    state_d   = state_q;
    last_wb_d = last_wb_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cpu_a_d   = cpu_a_q;
    wb_odd_d  = wb_odd_q;
    cpu_q_d   = cpu_q_q;
    wb_dat_d  = wb_dat_q;
    mem_a     = 14'h0000;
    mem_we    = 1'b0;
    mem_be    = 2'b00;
    mem_d     = 16'h0000;

    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          last_wb_d = 1'b0;
          cpu_a_d   = cpu_a;
          if (!cpu_mapped) begin
            // Outside the expansion windows: finish at once, reads return FFFF.
            cpu_q_d = 16'hFFFF;
            state_d = CPU_DONE;
          end else if (cpu_we) begin
            mem_a   = cpu_map;
            mem_we  = 1'b1;
            mem_be  = 2'b11;
            mem_d   = cpu_d;
            state_d = CPU_DONE;
          end else begin
            mem_a   = cpu_map;
            addr_d  = cpu_map;
            cnt_d   = 2'd0;
            state_d = CPU_RD;
          end
        end else if (grant_wb) begin
          last_wb_d = 1'b1;
          addr_d    = wb_adr_i[14:1];
          wb_odd_d  = wb_adr_i[0];
          if (!wb_sel_i) begin
            wb_dat_d = 8'hFF;
            state_d  = WB_ACK;
          end else if (wb_we_i) begin
            mem_a   = wb_adr_i[14:1];
            mem_we  = 1'b1;
            mem_be  = wb_adr_i[0] ? 2'b10 : 2'b01;
            mem_d   = {wb_dat_i, wb_dat_i};
            state_d = WB_ACK;
          end else begin
            mem_a   = wb_adr_i[14:1];
            cnt_d   = 2'd0;
            state_d = WB_RD;
          end
        end
      end
      CPU_RD: begin
        mem_a = addr_q;
        if (cnt_q == LAT_LAST) begin
          cpu_q_d = mem_q;
          state_d = CPU_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      CPU_DONE: begin
        // Hold ready until the CPU ends the cycle; a new address with cs still
        // high starts the next access. No grant is made in this exit cycle.
        if (!cpu_cs || (cpu_a != cpu_a_q)) begin
          state_d = IDLE;
        end
      end
      WB_RD: begin
        mem_a = addr_q;
        if (cnt_q == LAT_LAST) begin
          wb_dat_d = wb_odd_q ? mem_q[7:0] : mem_q[15:8];
          state_d  = WB_ACK;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WB_ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset cycle must never leave a write behind.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_wb_q <= 1'b1;
      cnt_q     <= 2'd0;
      addr_q    <= 14'h0000;
      cpu_a_q   <= 15'h0000;
      wb_odd_q  <= 1'b0;
      cpu_q_q   <= 16'h0000;
      wb_dat_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      last_wb_q <= last_wb_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      cpu_a_q   <= cpu_a_d;
      wb_odd_q  <= wb_odd_d;
      cpu_q_q   <= cpu_q_d;
      wb_dat_q  <= wb_dat_d;
    end
  end

  assign cpu_q     = cpu_q_q;
  assign wb_dat_o  = wb_dat_q;
  assign cpu_ready = !cpu_cs || (state_q == CPU_DONE);
  assign wb_ack_o  = (state_q == WB_ACK) && !reset;

endmodule
